dmem_arbiter: RTL
=================

# dmem_arbiter

Two-requester arbiter and sequencer in front of `data_mem`. It shares the single data memory between the CPU load/store path (port A) and a DMA/debug master (port B). It serialises accesses through a three-state FSM and range-checks addresses against the memory size. It returns a registered read word and a per-port acknowledge.

## Interface
- `DATA_MEM_BYTES`, default `'h3000`: memory size in bytes; addresses `>= DATA_MEM_BYTES` are rejected.
- `clock` in, 1: rising-edge clock.
- `reset` in, 1: synchronous, active-high.
- `a_req` / `b_req` in, 1: request valid; held with fields stable until that port's ack.
- `a_we` / `b_we` in, 1: 1 = store, 0 = load.
- `a_byte` / `b_byte` in, 1: byte access (forwarded as `byte_en`).
- `a_addr` / `b_addr` in, 32: byte address.
- `a_wdata` / `b_wdata` in, 32: store data (byte stores use bits 7:0).
- `a_ack` / `b_ack` out, 1: one-cycle completion pulse.
- `rsp_err` out, 1: valid with an ack; 1 = out-of-range address.
- `rsp_rdata` out, 32: load data, valid with an ack; 0 for stores and errors.
- `busy` out, 1: FSM not in IDLE.
- `mem_addr` out, 32: to `data_mem.addr`.
- `mem_read` out, 1: to `data_mem.memread`.
- `mem_write` out, 1: to `data_mem.memwrite`.
- `mem_byte_en` out, 1: to `data_mem.byte_en`.
- `mem_wdata` out, 32: to `data_mem.write_d`.
- `mem_rdata` in, 32: from `data_mem.read_d` (combinational).

## Operation
- Command registers hold the winner's `we`, `byte`, `addr`, `wdata`, owner (A/B) and `oob` flag (`addr >= DATA_MEM_BYTES`).
- **FSM states:**
  - **IDLE:** if any req is high, pick a winner, latch its command, go to ACCESS. Otherwise stay.
  - **ACCESS:** drive the mem ports from the command registers.
    - Not `oob`: `mem_read = ~we`, `mem_write = we`, so the store commits at the end of this cycle.
    - `oob`: both strobes are 0.
    - Capture `rsp_rdata` (`mem_rdata` if load and not `oob`, else 0) and `rsp_err = oob`. Go to RESP.
  - **RESP:** assert the owner's ack for exactly this cycle. Go to IDLE.
- A port whose req is still high in the IDLE cycle after its ack is treated as a new request.
- Outside ACCESS, `mem_read`, `mem_write`, `mem_byte_en`, `mem_addr` and `mem_wdata` are all 0.
- `mem_write` and `mem_read` are additionally gated by `~reset`, so no memory write is issued in a reset cycle.
- Address bits 1:0 pass through unmodified; byte-lane selection belongs to `data_mem`.
- Winner selection is fixed priority or round-robin (see Configuration). The round-robin pointer toggles to the other port after each grant.

## Timing
- Latency: req sampled high at edge N (IDLE) → ACCESS in cycle N+1 → ack in cycle N+2. Throughput is one access per 3 cycles.
- The store is written at the edge ending ACCESS. A load issued after a store's ack returns the new data.
- Simultaneous A and B requests in IDLE: exactly one is granted. The loser keeps req high and is granted in the next IDLE cycle (3 cycles later).
- Req falling before ack is a protocol violation. The latched command still completes and the ack is still issued.
- Reset, including mid-ACCESS or mid-RESP:
  - FSM returns to IDLE and the round-robin pointer to A.
  - Acks, `rsp_err` and `busy` are 0, and `rsp_rdata` is 0.
  - The in-flight request is dropped with no ack; the requester re-issues it.

## Configuration
- `DMEM_ARB_ROUND_ROBIN_EN` defined: round-robin.
  - On a tie, the port not granted most recently wins.
  - A single requester is always granted.
- Not defined: fixed priority, A always wins a tie. B can be starved by back-to-back A requests. The pointer register is not built.

## Test plan
- **Reset:** hold reset 2 cycles mid-ACCESS of an A store to `0x10`.
  - Required: all outputs 0, no ack, `mem_write` 0 during reset.
  - Then a load of `0x10` returns `0x00000000`.
- **Single access:** A stores word `0xDEADBEEF` to `0x20`, then loads `0x20`.
  - Required: each `a_ack` arrives 2 cycles after req, and the load gives `rsp_rdata = 0xDEADBEEF`.
- **Byte access:** B byte-stores `0xAB` to `0x21`, then word-loads `0x20`.
  - Required: `0xDEADABEF`.
  - Then a byte load of `0x21` returns `0x000000AB`.
- **Contention:** A and B both hold req continuously for 4 grants.
  - With the macro: acks alternate A, B, A, B, 3 cycles apart.
  - Without the macro: acks are A, A, A, A and B is never acked.
- **Out of range:** A loads `0x3000`, and B stores to `0xFFFFFFFC`.
  - Required: each acked with `rsp_err = 1`, `rsp_rdata = 0`, and `mem_read`/`mem_write` never high.
  - A later load of `0x2FFC` is unchanged.
- **Back-to-back:** A keeps req high through its ack with a new address.
  - Required: a second grant starts in the next IDLE, the second ack arrives 3 cycles after the first, and `busy` drops for exactly one cycle between them.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares data_mem between the CPU load/store port (A) and a
// DMA/debug master (B). Accesses run IDLE -> ACCESS -> RESP, one per 3 cycles.
// Out-of-range addresses are acknowledged with rsp_err and never reach memory.
// Optional feature macro: DMEM_ARB_ROUND_ROBIN_EN (round-robin winner
// selection); when undefined, port A has fixed priority.
module dmem_arbiter #(
    parameter int unsigned DATA_MEM_BYTES = 32'h3000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        a_req,
    input  logic        a_we,
    input  logic        a_byte,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    input  logic        b_req,
    input  logic        b_we,
    input  logic        b_byte,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    output logic        a_ack,
    output logic        b_ack,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic        busy,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_byte_en,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic          latch_cmd;
    logic          capture_rsp;

    logic          cmd_we_q;
    logic          cmd_byte_q;
    logic [AW-1:0] cmd_addr_q;
    logic [DW-1:0] cmd_wdata_q;
    logic          cmd_owner_q;   // 0 = port A, 1 = port B
    logic          cmd_oob_q;

    logic          pick_b;
    logic          sel_we;
    logic          sel_byte;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          sel_oob;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    logic          rr_ptr_q;      // 1 = B preferred on the next tie

    // Winner select: on a tie the port not granted most recently wins
    always_comb begin
        pick_b = b_req & (~a_req | rr_ptr_q);
    end

    // Pointer moves to the other port after every grant
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr_q <= 1'b0;
        end else if (latch_cmd) begin
            rr_ptr_q <= ~pick_b;
        end
    end
`else
    // Winner select: fixed priority, A wins every tie
    always_comb begin
        pick_b = b_req & ~a_req;
    end
`endif

    // Mux the winning port's command and range-check its address
    always_comb begin
        sel_we    = pick_b ? b_we    : a_we;
        sel_byte  = pick_b ? b_byte  : a_byte;
        sel_addr  = pick_b ? b_addr  : a_addr;
        sel_wdata = pick_b ? b_wdata : a_wdata;
        sel_oob   = sel_addr >= AW'(DATA_MEM_BYTES);
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-state control strobes
    always_comb begin
        state_d     = state_q;
        latch_cmd   = 1'b0;
        capture_rsp = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (a_req | b_req) begin
                    state_d   = ST_ACCESS;
                    latch_cmd = 1'b1;
                end
            end
            ST_ACCESS: begin
                state_d     = ST_RESP;
                capture_rsp = 1'b1;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Command registers hold the granted request for ACCESS
    always_ff @(posedge clock) begin
        if (reset) begin
            cmd_we_q    <= 1'b0;
            cmd_byte_q  <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            cmd_owner_q <= 1'b0;
            cmd_oob_q   <= 1'b0;
        end else if (latch_cmd) begin
            cmd_we_q    <= sel_we;
            cmd_byte_q  <= sel_byte;
            cmd_addr_q  <= sel_addr;
            cmd_wdata_q <= sel_wdata;
            cmd_owner_q <= pick_b;
            cmd_oob_q   <= sel_oob;
        end
    end

    // Response registers: acks are live only in RESP, data captured at end of ACCESS
    always_ff @(posedge clock) begin
        if (reset) begin
            a_ack     <= 1'b0;
            b_ack     <= 1'b0;
            busy      <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            a_ack <= capture_rsp & ~cmd_owner_q;
            b_ack <= capture_rsp &  cmd_owner_q;
            busy  <= state_d != ST_IDLE;
            if (capture_rsp) begin
                rsp_err   <= cmd_oob_q;
                rsp_rdata <= (~cmd_we_q & ~cmd_oob_q) ? mem_rdata : DW'(0);
            end
        end
    end

    // Memory port drive: quiet outside ACCESS, strobes suppressed for oob and reset
    always_comb begin
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_byte_en = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        if (state_q == ST_ACCESS) begin
            mem_addr    = cmd_addr_q;
            mem_wdata   = cmd_wdata_q;
            mem_byte_en = cmd_byte_q;
            mem_read    = ~cmd_we_q & ~cmd_oob_q & ~reset;
            mem_write   =  cmd_we_q & ~cmd_oob_q & ~reset;
        end
    end

endmodule
